// File: rtl/divisor_secuencial_pkg.sv
// Shared constants for the sequential restoring divider: default width,
// FSM state encodings and iteration-counter width.
package divisor_secuencial_pkg;

  localparam int ANCHO_Q_DEF = 12;
  localparam int ANCHO_CNT   = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } estado_t;

endpackage

// File: rtl/divisor_secuencial_paso.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor if the result stays non-negative.
module divisor_paso #(
  parameter int ANCHO_Q = 12
) (
  input  logic [ANCHO_Q-1:0] r,
  input  logic               bit_in,
  input  logic [ANCHO_Q-1:0] divisor,
  output logic [ANCHO_Q-1:0] r_nuevo,
  output logic               q_bit
);

  // Two extra bits: one for the shifted-in bit, one to catch the borrow.
  logic [ANCHO_Q+1:0] dif;
  logic               unused_bit;

  assign dif     = {1'b0, r, bit_in} - {2'b00, divisor};
  assign q_bit   = ~dif[ANCHO_Q+1];
  // A successful subtraction always leaves a value below the divisor, so
  // the top difference bit is zero whenever it is kept.
  assign r_nuevo = q_bit ? dif[ANCHO_Q-1:0] : {r[ANCHO_Q-2:0], bit_in};
  assign unused_bit = dif[ANCHO_Q];

endmodule

// File: rtl/divisor_secuencial.sv
// Sequential restoring divider: 2*ANCHO_Q-bit unsigned dividend by ANCHO_Q-bit
// divisor, one quotient bit per clock, start/done handshake.
module divisor_secuencial
  import divisor_secuencial_pkg::*;
#(
  parameter int ANCHO_Q = ANCHO_Q_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2*ANCHO_Q-1:0] in1,
  input  logic [ANCHO_Q-1:0]   in2,
  output logic                 ready,
  output logic                 done,
  output logic [ANCHO_Q-1:0]   out,
  output logic [ANCHO_Q-1:0]   resto,
  output logic                 ovf
);

  localparam logic [ANCHO_CNT-1:0] CNT_ULT = ANCHO_CNT'(ANCHO_Q - 1);

  estado_t              estado, estado_sig;
  // Partial remainder is kept ANCHO_Q wide: it is always below the divisor.
  logic [ANCHO_Q-1:0]   r, r_sig;
  logic [ANCHO_Q-1:0]   q, q_sig;
  logic [ANCHO_Q-1:0]   div_r, div_sig;
  logic [ANCHO_CNT-1:0] cnt, cnt_sig;
  logic [ANCHO_Q-1:0]   out_sig, resto_sig;
  logic                 ovf_sig;
  logic [ANCHO_Q-1:0]   r_paso;
  logic                 q_bit;

  divisor_paso #(.ANCHO_Q(ANCHO_Q)) u_paso (
    .r       (r),
    .bit_in  (q[ANCHO_Q-1]),
    .divisor (div_r),
    .r_nuevo (r_paso),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado <= S_IDLE;
      r      <= '0;
      q      <= '0;
      div_r  <= '0;
      cnt    <= '0;
      out    <= '0;
      resto  <= '0;
      ovf    <= 1'b0;
    end else begin
      estado <= estado_sig;
      r      <= r_sig;
      q      <= q_sig;
      div_r  <= div_sig;
      cnt    <= cnt_sig;
      out    <= out_sig;
      resto  <= resto_sig;
      ovf    <= ovf_sig;
    end
  end

  always_comb begin
    estado_sig = estado;
    r_sig      = r;
    q_sig      = q;
    div_sig    = div_r;
    cnt_sig    = cnt;
    out_sig    = out;
    resto_sig  = resto;
    ovf_sig    = ovf;
    unique case (estado)
      S_IDLE: begin
        if (start) begin
          div_sig = in2;
          // Quotient would not fit in ANCHO_Q bits (or divisor is zero).
          if ((in2 == '0) || (in1[2*ANCHO_Q-1:ANCHO_Q] >= in2)) begin
            out_sig    = '1;
            resto_sig  = '0;
            ovf_sig    = 1'b1;
            estado_sig = S_FIN;
          end else begin
            r_sig      = in1[2*ANCHO_Q-1:ANCHO_Q];
            q_sig      = in1[ANCHO_Q-1:0];
            cnt_sig    = '0;
            estado_sig = S_RUN;
          end
        end
      end
      S_RUN: begin
        r_sig   = r_paso;
        q_sig   = {q[ANCHO_Q-2:0], q_bit};
        cnt_sig = cnt + 1'b1;
        if (cnt == CNT_ULT) begin
          out_sig    = {q[ANCHO_Q-2:0], q_bit};
          resto_sig  = r_paso;
          ovf_sig    = 1'b0;
          estado_sig = S_FIN;
        end
      end
      S_FIN:   estado_sig = S_IDLE;
      default: estado_sig = S_IDLE;
    endcase
  end

  assign ready = (estado == S_IDLE);
  assign done  = (estado == S_FIN);

endmodule

// File: tb/tb_divisor_secuencial.sv
// Scoreboard bench for divisor_secuencial: stimulus pushes expected results
// computed with plain division, a negedge monitor pops them on every done.
module tb_divisor_secuencial;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [23:0] in1;
  logic [11:0] in2;
  logic        ready, done, ovf;
  logic [11:0] out, resto;

  typedef struct {
    logic [23:0] a;
    logic [11:0] b;
    logic [11:0] q_exp;
    logic [11:0] r_exp;
    logic        ovf_exp;
    int          acc;
  } item_t;

  item_t sb[$];
  int total = 0;
  int bad   = 0;
  int edge_cnt = 0;

  divisor_secuencial #(.ANCHO_Q(12)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .in1   (in1),
    .in2   (in2),
    .ready (ready),
    .done  (done),
    .out   (out),
    .resto (resto),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string nombre, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nombre, act, exp, $time);
    end
  endtask

  function automatic item_t modelo(input logic [23:0] a, input logic [11:0] b, input int acc);
    item_t it;
    int unsigned ai, bi;
    ai = a;
    bi = b;
    it.a = a;
    it.b = b;
    it.acc = acc;
    if (bi == 0 || (ai / bi) > 4095) begin
      it.q_exp = 12'hFFF;
      it.r_exp = 12'h000;
      it.ovf_exp = 1'b1;
    end else begin
      it.q_exp = 12'(ai / bi);
      it.r_exp = 12'(ai % bi);
      it.ovf_exp = 1'b0;
    end
    return it;
  endfunction

  // Issue one division once ready, then scramble the inputs to prove latching.
  task automatic dividir(input logic [23:0] a, input logic [11:0] b);
    int n = 0;
    while (!ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ready) check("ready_wait", {31'd0, ready}, 32'd1);
    in1 = a;
    in2 = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back(modelo(a, b, edge_cnt));
    start = 1'b0;
    in1 = 24'($urandom);
    in2 = 12'($urandom);
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_done: got done=1 want no pending division (t=%0t)", $time);
      end else begin
        item_t it;
        it = sb.pop_front();
        check("out", {20'd0, out}, {20'd0, it.q_exp});
        check("resto", {20'd0, resto}, {20'd0, it.r_exp});
        check("ovf", {31'd0, ovf}, {31'd0, it.ovf_exp});
        check("latency", edge_cnt - it.acc, it.ovf_exp ? 32'd0 : 32'd12);
        check("ready_in_fin", {31'd0, ready}, 32'd0);
        if (!it.ovf_exp) begin
          check("invariant", out * it.b + resto, {8'd0, it.a});
          check("resto_lt_div", {31'd0, (resto < it.b)}, 32'd1);
        end
      end
    end
  end

  initial begin
    int n;
    rst_n = 1'b0;
    start = 1'b0;
    in1 = '0;
    in2 = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_out", {20'd0, out}, 32'd0);
    check("rst_resto", {20'd0, resto}, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    dividir(24'h000064, 12'h00A);
    dividir(24'h0B696D, 12'h64D);
    dividir(24'h100000, 12'h001);
    dividir(24'h100000, 12'h000);
    dividir(24'hFFFFFF, 12'hFFF);
    dividir(24'hFFEFFF, 12'hFFF);
    dividir(24'h000000, 12'h001);

    // Start pulses during RUN and FIN must be ignored.
    dividir(24'h000064, 12'h00A);
    for (int i = 0; i < 13; i++) begin
      in1 = 24'($urandom);
      in2 = 12'($urandom);
      start = 1'b1;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("ignored_starts", sb.size(), 32'd0);

    // Start held high: next division accepted on the first IDLE edge after FIN.
    in1 = 24'h000FFF;
    in2 = 12'h010;
    start = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back(modelo(24'h000FFF, 12'h010, edge_cnt));
    repeat (14) @(posedge clk);
    #1;
    sb.push_back(modelo(24'h000FFF, 12'h010, edge_cnt));
    start = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("held_start_drained", sb.size(), 32'd0);

    // Asynchronous reset in the middle of RUN discards the division.
    dividir(24'h0B696D, 12'h64D);
    repeat (6) @(posedge clk);
    #3;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("arst_out", {20'd0, out}, 32'd0);
    check("arst_resto", {20'd0, resto}, 32'd0);
    check("arst_ovf", {31'd0, ovf}, 32'd0);
    check("arst_ready", {31'd0, ready}, 32'd1);
    check("arst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (16) @(negedge clk);
    dividir(24'h000FFF, 12'h010);

    // Random sweep: mostly in-range pairs, with an occasional unconstrained one.
    for (int i = 0; i < 400; i++) begin
      logic [11:0] b, hi, lo;
      b  = 12'($urandom_range(4095, 1));
      hi = 12'($urandom_range(int'(b) - 1, 0));
      lo = 12'($urandom);
      if (i % 8 == 7) dividir(24'($urandom), 12'($urandom));
      else dividir({hi, lo}, b);
    end

    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("final_drained", sb.size(), 32'd0);
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
